// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam int unsigned DEF_WIDTH = 8;

    // Step counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add for MUL, restoring subtract for DIV.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             q_bit,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        acc_nxt = acc;
        q_bit   = 1'b0;
        a_nxt   = a << 1;
        b_nxt   = b;
        shifted = '0;
        trial   = '0;
        if (op == OP_MUL) begin
            acc_nxt = acc + (b[0] ? a : '0);
            b_nxt   = b >> 1;
        end else begin
            // Remainder stays below b, so the shifted value needs one extra bit.
            shifted = {acc, a[WIDTH-1]};
            trial   = shifted - {1'b0, b};
            if (!trial[WIDTH]) begin
                acc_nxt = trial[WIDTH-1:0];
                q_bit   = 1'b1;
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Single-outstanding iterative unsigned MUL/DIV sequencer with valid/ready on both sides.
// Optional remainder output enabled by defining MULDIV_REM_EN.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_dz
`ifdef MULDIV_REM_EN
    ,
    output logic [WIDTH-1:0] out_rem
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state, state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_q;

    logic [WIDTH-1:0] acc_nxt, a_nxt, b_nxt;
    logic             q_bit;
    logic             accept, div_zero, last_step;

    assign accept    = in_valid && in_ready;
    assign div_zero  = (in_op == OP_DIV) && (in_b == '0);
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc     (acc_q),
        .a       (a_q),
        .b       (b_q),
        .acc_nxt (acc_nxt),
        .q_bit   (q_bit),
        .a_nxt   (a_nxt),
        .b_nxt   (b_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)    state_nxt = div_zero ? S_DONE : S_BUSY;
            S_BUSY: if (last_step) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // For DIV the dividend register collects quotient bits from the LSB as it shifts out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q  <= op_e'(in_op);
                    a_q   <= in_a;
                    b_q   <= in_b;
                    acc_q <= '0;
                    cnt_q <= '0;
                    dz_q  <= div_zero;
                    if (div_zero) res_q <= '1;
                end
                S_BUSY: begin
                    acc_q <= acc_nxt;
                    a_q   <= a_nxt | WIDTH'(q_bit);
                    b_q   <= b_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step)
                        res_q <= (op_q == OP_MUL) ? acc_nxt : (a_nxt | WIDTH'(q_bit));
                end
                default: ;
            endcase
        end
    end

    assign out_res = res_q;
    assign out_dz  = dz_q;

`ifdef MULDIV_REM_EN
    logic [WIDTH-1:0] rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else if (state == S_IDLE && accept && div_zero) begin
            rem_q <= in_a;
        end else if (state == S_BUSY && last_step) begin
            rem_q <= (op_q == OP_DIV) ? acc_nxt : '0;
        end
    end

    assign out_rem = rem_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: reference model, latency, backpressure, pending request, reset abort.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_op = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_res;
    logic         out_dz;
`ifdef MULDIV_REM_EN
    logic [W-1:0] out_rem;
`endif

    muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_dz    (out_dz)
`ifdef MULDIV_REM_EN
        ,
        .out_rem   (out_rem)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        logic [W-1:0] rem;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input int a, input int b);
        exp_t e;
        if (op == OP_MUL) begin
            e.res = W'((a * b) % 256);
            e.dz  = 1'b0;
            e.rem = '0;
            e.lat = W + 1;
        end else if (b == 0) begin
            e.res = 8'hFF;
            e.dz  = 1'b1;
            e.rem = W'(a);
            e.lat = 1;
        end else begin
            e.res = W'(a / b);
            e.dz  = 1'b0;
            e.rem = W'(a % b);
            e.lat = W + 1;
        end
        return e;
    endfunction

    // Drive a request and wait for its accepting edge; returns #1 after that edge.
    task automatic issue(input logic op, input int a, input int b);
        bit acc = 0;
        sb.push_back(model(op, a, b));
        in_op    = op;
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    // Called #1 after the accepting edge; counts edges until out_valid and scores the result.
    task automatic wait_result(input string tag);
        exp_t e;
        int   lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({tag, "_res"}, 32'(out_res), 32'(e.res));
        check({tag, "_dz"}, 32'(out_dz), 32'(e.dz));
`ifdef MULDIV_REM_EN
        check({tag, "_rem"}, 32'(out_rem), 32'(e.rem));
`endif
    endtask

    task automatic hold_check(input int n);
        logic [W-1:0] snap = out_res;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_res", 32'(out_res), 32'(snap));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic op, input int a, input int b);
        issue(op, a, b);
        wait_result(tag);
        release_result();
    endtask

    initial begin
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_dz", 32'(out_dz), 32'd0);
`ifdef MULDIV_REM_EN
        check("rst_out_rem", 32'(out_rem), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_13x11", OP_MUL, 13, 11);
        run_op("mul_200x3", OP_MUL, 200, 3);
        run_op("mul_255x255", OP_MUL, 255, 255);
        run_op("div_100_7", OP_DIV, 100, 7);
        run_op("div_7_100", OP_DIV, 7, 100);
        run_op("div_255_1", OP_DIV, 255, 1);
        run_op("div_255_255", OP_DIV, 255, 255);
        run_op("div_55_0", OP_DIV, 55, 0);

        // Backpressure with a request left pending across DONE.
        issue(OP_MUL, 77, 5);
        wait_result("bp_mul");
        sb.push_back(model(OP_DIV, 200, 9));
        in_op    = OP_DIV;
        in_a     = 8'd200;
        in_b     = 8'd9;
        in_valid = 1'b1;
        hold_check(5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pend_idle_valid", 32'(out_valid), 32'd0);
        check("pend_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pend_accepted", 32'(in_ready), 32'd0);
        wait_result("pend_div");
        release_result();

        for (int i = 0; i < 6; i++) begin
            logic op = 1'($urandom_range(0, 1));
            run_op(op ? "rnd_div" : "rnd_mul", op, int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)));
        end

        // Reset during BUSY step 4: accept edge, then four step edges, then abort.
        in_op    = OP_MUL;
        in_a     = 8'd100;
        in_b     = 8'd100;
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_pre_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_res", 32'(out_res), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        check("abort_idle", 32'(in_ready), 32'd1);
        run_op("post_rst_mul_2x3", OP_MUL, 2, 3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
